// File: rtl/mux64_share_arbiter.sv
// Round-robin owner of a shared 64-bit 2:1 data path (A/B) with a bounded burst per grant.
// Grant, select and burst count are registered; data, valid and ready are combinational from them.
module mux64_share_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CW        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [63:0] data_a,
  output logic        gnt_a,
  output logic        rdy_a,
  input  logic        req_b,
  input  logic [63:0] data_b,
  output logic        gnt_b,
  output logic        rdy_b,
  output logic [63:0] o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        sel,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;

  // Handshake: a beat moves downstream in any cycle where o_valid & o_ready;
  // the owning requester sees rdy_x in that cycle and must hold data_x until then.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_b_q)) begin
          state_d = OWN_A;
          sel_d   = 1'b0;
        end else if (req_b) begin
          state_d = OWN_B;
          sel_d   = 1'b1;
        end
      end
      OWN_A: begin
        if (req_a && o_ready) cnt_d = cnt_q + 1'b1;
        if (!req_a || (o_ready && cnt_q == LAST_CNT)) begin
          cnt_d    = '0;
          last_b_d = 1'b0;
          // Direct handover saves the idle cycle; a lone requester hitting the
          // burst limit still goes through IDLE so re-arbitration is visible.
          if (req_b) begin
            state_d = OWN_B;
            sel_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OWN_B: begin
        if (req_b && o_ready) cnt_d = cnt_q + 1'b1;
        if (!req_b || (o_ready && cnt_q == LAST_CNT)) begin
          cnt_d    = '0;
          last_b_d = 1'b1;
          if (req_a) begin
            state_d = OWN_A;
            sel_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

  assign gnt_a   = (state_q == OWN_A);
  assign gnt_b   = (state_q == OWN_B);
  assign busy    = (state_q != IDLE);
  assign sel     = sel_q;
  assign rdy_a   = gnt_a & o_ready;
  assign rdy_b   = gnt_b & o_ready;
  assign o_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign o_data  = sel_q ? data_b : data_a;

endmodule

// File: tb/tb_mux64_share_arbiter.sv
// Bench for mux64_share_arbiter: a per-cycle vector table followed by directed
// multi-cycle sequences (burst limit, handover, backpressure, early release, async reset).
module tb_mux64_share_arbiter;

  localparam int MB = 16;

  logic        clk;
  logic        rst;
  logic        req_a, req_b, o_ready;
  logic [63:0] data_a, data_b;
  logic        gnt_a, gnt_b, rdy_a, rdy_b, o_valid, sel, busy;
  logic [63:0] o_data;

  int checks   = 0;
  int failures = 0;
  int ia       = 0;
  int ib       = 0;
  logic [63:0] exp_q[$];

  mux64_share_arbiter #(.MAX_BURST(MB), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a), .rdy_a(rdy_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b), .rdy_b(rdy_b),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .sel(sel), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fields: rst req_a req_b o_ready | gnt_a gnt_b sel busy
  typedef struct packed {
    logic rst, ra, rb, rdy;
    logic ga, gb, sel, busy;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [63:0] word_a(input int i);
    return {32'hA0A0_0000, 32'(i)};
  endfunction

  function automatic logic [63:0] word_b(input int i);
    return {32'hB0B0_0000, 32'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: new inputs just after the falling edge, outputs sampled 1ns later
  task automatic drive(input logic r, input logic ra, input logic rb, input logic rdy);
    @(negedge clk);
    rst     = r;
    req_a   = ra;
    req_b   = rb;
    o_ready = rdy;
    data_a  = word_a(ia);
    data_b  = word_b(ib);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic ga, input logic gb,
                             input logic s, input logic bz);
    chk({tag, " gnt_a"},   64'(gnt_a),   64'(ga));
    chk({tag, " gnt_b"},   64'(gnt_b),   64'(gb));
    chk({tag, " sel"},     64'(sel),     64'(s));
    chk({tag, " busy"},    64'(busy),    64'(bz));
    chk({tag, " o_valid"}, 64'(o_valid), 64'((ga & req_a) | (gb & req_b)));
    chk({tag, " rdy_a"},   64'(rdy_a),   64'(ga & o_ready));
    chk({tag, " rdy_b"},   64'(rdy_b),   64'(gb & o_ready));
    chk({tag, " o_data"},  o_data,       s ? data_b : data_a);
    if (ga && req_a && o_ready) ia++;
    if (gb && req_b && o_ready) ib++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    ia    = 0;
    ib    = 0;
  endtask

  initial begin
    logic ra, rb, rdy, ga, gb, s;
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; o_ready = 1'b1;
    data_a = '0; data_b = '0;

    tbl = '{
      8'b1111_0000, 8'b1111_0000, 8'b1111_0000,  // reset held with both requesting
      8'b0111_0000,                              // released, grant not yet visible
      8'b0111_1001, 8'b0111_1001, 8'b0111_1001,  // A wins the tie, 3 beats
      8'b0011_1001,                              // A drops request
      8'b0111_0111,                              // direct handover to B
      8'b0110_0111,                              // B stalled
      8'b0100_0111,                              // B drops while stalled
      8'b0001_1001,                              // handover to A, A already gone
      8'b0001_0000,                              // idle
      8'b0010_0000,                              // B requests alone
      8'b0000_0111,                              // B granted, already dropped
      8'b0000_0010,                              // idle, sel holds 1
      8'b0111_0010,                              // tie after B served
      8'b0000_1001,                              // A wins
      8'b0000_0000
    };

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].ra, tbl[i].rb, tbl[i].rdy);
      check_cycle($sformatf("vec%0d", i), tbl[i].ga, tbl[i].gb, tbl[i].sel, tbl[i].busy);
    end

    // single requester: 16-beat burst, one idle cycle, re-grant
    ia = 0;
    for (int i = 0; i < 20; i++) exp_q.push_back(word_a(i));
    for (int c = 0; c < 24; c++) begin
      ra = (ia < 20);
      drive(1'b0, ra, 1'b0, 1'b1);
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) chk("burst extra_beat", o_data, '0);
        else chk($sformatf("burst beat c%0d", c), o_data, exp_q.pop_front());
      end
      ga = (c >= 1 && c <= 16) || (c >= 18 && c <= 22);
      check_cycle($sformatf("burst c%0d", c), ga, 1'b0, 1'b0, ga);
    end
    chk("burst beats_left", 64'(exp_q.size()), 64'd0);

    // contention: A 16, B 16, A again, no idle between
    pulse_reset();
    for (int c = 0; c < 35; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      ga = (c >= 1 && c <= 16) || (c >= 33);
      gb = (c >= 17 && c <= 32);
      check_cycle($sformatf("contend c%0d", c), ga, gb, gb, ga | gb);
    end

    // backpressure in OWN_B after 5 beats
    pulse_reset();
    for (int c = 0; c < 29; c++) begin
      rdy = !(c >= 6 && c <= 15);
      drive(1'b0, 1'b0, 1'b1, rdy);
      gb = (c >= 1 && c <= 26) || (c == 28);
      s  = (c >= 1);
      check_cycle($sformatf("bp c%0d", c), 1'b0, gb, s, gb);
    end

    // early release of A, A re-requests and waits out B's burst
    pulse_reset();
    for (int c = 0; c < 23; c++) begin
      ra = (c != 4);
      drive(1'b0, ra, 1'b1, 1'b1);
      ga = (c >= 1 && c <= 4) || (c >= 21);
      gb = (c >= 5 && c <= 20);
      check_cycle($sformatf("early c%0d", c), ga, gb, gb, ga | gb);
    end

    // async reset during beat 7 of OWN_B
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      check_cycle($sformatf("arst c%0d", c), 1'b0, c >= 1, c >= 1, c >= 1);
    end
    #1 rst = 1'b1;
    #1;
    check_cycle("arst mid", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      check_cycle($sformatf("arst tie c%0d", c), c == 1, 1'b0, 1'b0, c == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux64_share_arbiter.md
Name: mux64_share_arbiter

Overview:
- Shares one 64-bit 2:1 data path between two requesters, A and B, feeding a single downstream consumer (e.g. the display/frame-data sink).
- Owns the path select. It grants one requester at a time under round-robin priority with a bounded burst length.
- Exposes a valid/ready handshake on both the upstream and downstream sides.
- The 64-bit selection (sel=0 passes A, sel=1 passes B) is implemented inside the block.

Parameters:
- MAX_BURST, 16: maximum beats transferred per grant before a forced re-arbitration; legal range 1..255.
- CW, 8: burst counter width; must satisfy 2^CW > MAX_BURST.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A has valid data.
- data_a  input  64  requester A data.
- gnt_a  output  1  A currently owns the path.
- rdy_a  output  1  A beat accepted this cycle (gnt_a & o_ready).
- req_b  input  1  requester B has valid data.
- data_b  input  64  requester B data.
- gnt_b  output  1  B currently owns the path.
- rdy_b  output  1  B beat accepted this cycle (gnt_b & o_ready).
- o_data  output  64  selected data: sel ? data_b : data_a.
- o_valid  output  1  gnt_a&req_a | gnt_b&req_b.
- o_ready  input  1  downstream accepts a beat when o_valid & o_ready.
- sel  output  1  registered path select (0=A, 1=B).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, gnt_a=gnt_b=0, burst count=0, last_served=B (A wins the first tie). o_valid, rdy_a and rdy_b are therefore 0.
- State machine states: IDLE, OWN_A, OWN_B. The state, sel, the grants and the counter are registered. o_data, o_valid, rdy_a and rdy_b are combinational from the registered grant state.
- IDLE:
  - Only req_a -> OWN_A, sel=0.
  - Only req_b -> OWN_B, sel=1.
  - Both -> the requester that is not last_served wins.
  - Neither -> stay in IDLE.
  - Grant appears one cycle after the request. There are no data beats in IDLE.
- OWN_X: a beat completes in a cycle where req_x & o_ready; the counter increments. Leave OWN_X at the next edge when either condition holds:
  - (a) req_x=0 in this cycle, or
  - (b) a beat completes and count+1 == MAX_BURST.
- On leaving OWN_X: last_served=X, count=0.
  - If the other requester's req is high in the same cycle -> go directly to OWN_other with sel flipped. This handover costs no IDLE cycle.
  - Otherwise -> IDLE.
  - Under condition (b), if the other requester is idle and req_x is still high -> return to IDLE, then re-grant X on the following cycle, so re-arbitration is always observable.
- Backpressure: with o_ready=0, the count holds, the grant holds and no beat completes. The requester must hold data_x stable while req_x & !rdy_x.
- req_x dropping mid-burst with o_ready=0: the grant is still released per (a). No beat is lost, because none completed.
- A requester that is not granted never sees rdy.
- gnt_a and gnt_b are never both 1. sel changes only on a grant transition.
- Reset mid-burst: all state clears immediately. The partial burst is abandoned and the counter is not preserved.
- MAX_BURST=1 degenerates to per-beat round-robin with alternating grants when both requesters are active.

Test Plan:
- Reset then idle: rst=1 for 3 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, sel=0, o_valid=0. Release rst -> gnt_a=1 at the 1st edge (A wins the tie); o_data=data_a.
- Single requester burst: req_a held, o_ready=1, MAX_BURST=16, data_a = beat index 0..19 -> beats 0..15 accepted. Then 1 IDLE cycle (gnt_a=0, busy=0), then re-grant A; beats 16..19 follow.
- Contention handover: req_a and req_b both held, o_ready=1 -> A 16 beats, then B 16 beats with zero idle cycles between. sel toggles 0->1 exactly at the handover; gnt_a/gnt_b are never both 1.
- Backpressure: in OWN_B after 5 beats, o_ready=0 for 10 cycles -> rdy_b=0, count stays 5, o_data=data_b stable. o_ready=1 -> 11 more beats, then release.
- Early release: req_a drops after 3 beats while req_b=1 -> next cycle gnt_b=1, sel=1. A, re-requesting, waits until B's burst completes.
- Async reset mid-burst: assert rst between clock edges during beat 7 of OWN_B -> gnt_b, sel and busy go to 0 before the next edge. After release, a tie goes to A.
